// File: rtl/lsu_tlul_host.sv
// lsu_tlul_host
//   Upstream host adapter for the data-memory path. It turns the core LSU
//   req/gnt/rvalid handshake into TL-UL A/D channel transactions. It derives
//   opcode, size, aligned address and mask from the byte enables, and keeps up
//   to MaxOutstanding in-order requests in flight. Responses and errors are
//   handed back to the core in the same cycle they arrive.
//
// Ports
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   data_req_i       core request valid (held stable until data_gnt_o)
//   data_we_i        1 = store, 0 = load
//   data_be_i        byte enables, bit n = byte lane n
//   data_addr_i      byte address (bits [1:0] ignored, lanes come from data_be_i)
//   data_wdata_i     lane-aligned store data
//   data_gnt_o       request accepted this cycle
//   data_rvalid_o    one-cycle response strobe, in request order
//   data_rdata_o     load data, 0 for store responses
//   data_err_o       response error, qualified by data_rvalid_o
//   tl_h_o / tl_h_i  TL-UL host-to-device / device-to-host bundles

package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;

  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module lsu_tlul_host
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SrcW           = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output tl_h2d_t     tl_h_o,
  input  tl_d2h_t     tl_h_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [SrcW-1:0] src_q, src_d;
  logic [SrcW-1:0] rsp_src_q, rsp_src_d;

  logic       a_valid;
  logic       grant;
  logic       rsp;
  logic [1:0] a_size;
  logic [1:0] addr_lo;
  logic [2:0] a_opcode;

  // Low address bits are intentionally ignored; the byte lanes decide them.
  logic unused_addr;
  assign unused_addr = ^data_addr_i[1:0];

  // Handshake qualification. a_valid is gated by rst_ni so nothing is offered
  // to the crossbar while reset is held. A response only counts when a request
  // is actually outstanding; anything else is spurious and dropped.
  always_comb begin
    a_valid = rst_ni && data_req_i && (outstanding_q < MaxCnt);
    grant   = a_valid && tl_h_i.a_ready;
    rsp     = tl_h_i.d_valid && (outstanding_q != '0);
  end

  // Size and low address bits from the byte-enable pattern. Naturally aligned
  // halfword and byte patterns shrink the access; every other pattern
  // (including 0000) goes out as a full word with the mask as given.
  always_comb begin
    a_size  = 2'd2;
    addr_lo = 2'd0;
    case (data_be_i)
      4'b0011: begin a_size = 2'd1; addr_lo = 2'd0; end
      4'b1100: begin a_size = 2'd1; addr_lo = 2'd2; end
      4'b0001: begin a_size = 2'd0; addr_lo = 2'd0; end
      4'b0010: begin a_size = 2'd0; addr_lo = 2'd1; end
      4'b0100: begin a_size = 2'd0; addr_lo = 2'd2; end
      4'b1000: begin a_size = 2'd0; addr_lo = 2'd3; end
      default: begin a_size = 2'd2; addr_lo = 2'd0; end
    endcase
  end

  always_comb begin
    a_opcode = Get;
    if (data_we_i) begin
      a_opcode = (data_be_i == 4'b1111) ? PutFullData : PutPartialData;
    end
  end

  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = a_valid;
    tl_h_o.a_opcode  = a_opcode;
    tl_h_o.a_param   = 3'd0;
    tl_h_o.a_size    = a_size;
    tl_h_o.a_source  = 8'(src_q);
    tl_h_o.a_address = {data_addr_i[31:2], addr_lo};
    tl_h_o.a_mask    = data_be_i;
    tl_h_o.a_data    = data_we_i ? data_wdata_i : 32'd0;
    tl_h_o.d_ready   = 1'b1;
  end

  // Core-side response. A source that does not match the next expected one is
  // reported as an error but still retires the oldest request.
  always_comb begin
    data_gnt_o    = grant;
    data_rvalid_o = rsp;
    data_rdata_o  = (rsp && (tl_h_i.d_opcode == AccessAckData)) ? tl_h_i.d_data : 32'd0;
    data_err_o    = rsp && (tl_h_i.d_error || (tl_h_i.d_source != 8'(rsp_src_q)));
  end

  // Grant and counted response in the same cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({grant, rsp})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    src_d     = grant ? src_q + 1'b1 : src_q;
    rsp_src_d = rsp ? rsp_src_q + 1'b1 : rsp_src_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      src_q         <= '0;
      rsp_src_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      src_q         <= src_d;
      rsp_src_q     <= rsp_src_d;
    end
  end

endmodule

// File: tb/tb_lsu_tlul_host.sv
// tb_lsu_tlul_host
//   Self-checking bench for lsu_tlul_host. A-channel fields are compared
//   against hand-derived constants right after a request is driven; expected
//   core responses are queued when each request is issued and retired by a
//   monitor whenever the DUT raises data_rvalid_o.

module tb_lsu_tlul_host;
  import tlul_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  tl_h2d_t     tl_h_o;
  tl_d2h_t     tl_h_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_rsp_t;

  exp_rsp_t expQ[$];
  int numCompared   = 0;
  int numMismatched = 0;

  lsu_tlul_host #(.MaxOutstanding(2), .SrcW(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_gnt_o   (data_gnt_o),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .tl_h_o       (tl_h_o),
    .tl_h_i       (tl_h_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: every rvalid retires the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rst_ni && data_rvalid_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rvalid", 64'(data_rvalid_o), 64'd0);
      end else begin
        exp_rsp_t e;
        e = expQ.pop_front();
        checkOutput("rsp_rdata", 64'(data_rdata_o), 64'(e.rdata));
        checkOutput("rsp_err", 64'(data_err_o), 64'(e.err));
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
  endtask

  task automatic checkA(input string tag, input logic [2:0] op, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [7:0] src);
    checkOutput({tag, "_gnt"},    64'(data_gnt_o),       64'd1);
    checkOutput({tag, "_opcode"}, 64'(tl_h_o.a_opcode),  64'(op));
    checkOutput({tag, "_size"},   64'(tl_h_o.a_size),    64'(sz));
    checkOutput({tag, "_addr"},   64'(tl_h_o.a_address), 64'(addr));
    checkOutput({tag, "_mask"},   64'(tl_h_o.a_mask),    64'(mask));
    checkOutput({tag, "_data"},   64'(tl_h_o.a_data),    64'(data));
    checkOutput({tag, "_source"}, 64'(tl_h_o.a_source),  64'(src));
  endtask

  task automatic pushExp(input logic [31:0] rdata, input logic err);
    exp_rsp_t e;
    e.rdata = rdata;
    e.err   = err;
    expQ.push_back(e);
  endtask

  task automatic grantAndRelease();
    @(posedge clk_i);
    #1;
    data_req_i = 1'b0;
  endtask

  task automatic respond(input logic [2:0] op, input logic [31:0] data,
                         input logic [7:0] src, input logic err);
    tl_h_i.d_valid  = 1'b1;
    tl_h_i.d_opcode = op;
    tl_h_i.d_data   = data;
    tl_h_i.d_source = src;
    tl_h_i.d_error  = err;
    @(posedge clk_i);
    #1;
    tl_h_i.d_valid = 1'b0;
    tl_h_i.d_error = 1'b0;
  endtask

  task automatic resetDut();
    rst_ni         = 1'b0;
    data_req_i     = 1'b0;
    tl_h_i.d_valid = 1'b0;
    expQ.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    tl_h_i       = '0;
    tl_h_i.a_ready = 1'b1;
    // Busy inputs during reset: nothing may leak to either side.
    applyStimulus(1'b1, 4'hF, 32'h100, 32'h1);
    tl_h_i.d_valid  = 1'b1;
    tl_h_i.d_opcode = AccessAckData;
    tl_h_i.d_data   = 32'hFFFF_FFFF;
    #2;
    checkOutput("rst_a_valid", 64'(tl_h_o.a_valid), 64'd0);
    checkOutput("rst_gnt",     64'(data_gnt_o),     64'd0);
    checkOutput("rst_rvalid",  64'(data_rvalid_o),  64'd0);
    checkOutput("rst_err",     64'(data_err_o),     64'd0);
    checkOutput("rst_rdata",   64'(data_rdata_o),   64'd0);
    checkOutput("rst_d_ready", 64'(tl_h_o.d_ready), 64'd1);
    data_req_i     = 1'b0;
    tl_h_i.d_valid = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    $display("[TB] full-word store");
    applyStimulus(1'b1, 4'b1111, 32'h100, 32'hDEAD_BEEF);
    #1;
    checkA("t1", 3'd0, 2'd2, 32'h100, 4'hF, 32'hDEAD_BEEF, 8'd0);
    pushExp(32'h0, 1'b0);
    grantAndRelease();
    respond(AccessAck, 32'h1234_5678, 8'd0, 1'b0);

    $display("[TB] byte load");
    applyStimulus(1'b0, 4'b0100, 32'h202, 32'hFFFF_FFFF);
    #1;
    checkA("t2", 3'd4, 2'd0, 32'h202, 4'h4, 32'h0, 8'd1);
    pushExp(32'h00AB_0000, 1'b0);
    grantAndRelease();
    respond(AccessAckData, 32'h00AB_0000, 8'd1, 1'b0);

    $display("[TB] partial stores and halfword load");
    applyStimulus(1'b1, 4'b0101, 32'h10, 32'h1122_3344);
    #1;
    checkA("t3_be5", 3'd1, 2'd2, 32'h10, 4'h5, 32'h1122_3344, 8'd2);
    pushExp(32'h0, 1'b0);
    grantAndRelease();
    respond(AccessAck, 32'h0, 8'd2, 1'b0);

    applyStimulus(1'b1, 4'b1100, 32'h10, 32'hAABB_0000);
    #1;
    checkA("t3_beC", 3'd1, 2'd1, 32'h12, 4'hC, 32'hAABB_0000, 8'd3);
    pushExp(32'h0, 1'b0);
    grantAndRelease();
    respond(AccessAck, 32'h0, 8'd3, 1'b0);

    tl_h_i.a_ready = 1'b0;
    applyStimulus(1'b1, 4'b1000, 32'h20, 32'h7700_0000);
    #1;
    checkOutput("t3_noready_a_valid", 64'(tl_h_o.a_valid), 64'd1);
    checkOutput("t3_noready_gnt",     64'(data_gnt_o),     64'd0);
    @(posedge clk_i);
    #1;
    tl_h_i.a_ready = 1'b1;
    #1;
    checkA("t3_be8", 3'd1, 2'd0, 32'h23, 4'h8, 32'h7700_0000, 8'd0);
    pushExp(32'h0, 1'b0);
    grantAndRelease();
    respond(AccessAck, 32'h0, 8'd0, 1'b0);

    applyStimulus(1'b0, 4'b0011, 32'h46, 32'h5555_5555);
    #1;
    checkA("t3_ld3", 3'd4, 2'd1, 32'h44, 4'h3, 32'h0, 8'd1);
    pushExp(32'h0000_BEEF, 1'b0);
    grantAndRelease();
    respond(AccessAckData, 32'h0000_BEEF, 8'd1, 1'b0);

    $display("[TB] outstanding limit");
    resetDut();
    applyStimulus(1'b0, 4'hF, 32'h300, 32'h0);
    #1;
    checkA("t4_a", 3'd4, 2'd2, 32'h300, 4'hF, 32'h0, 8'd0);
    pushExp(32'hA0A0_A0A0, 1'b0);
    grantAndRelease();
    applyStimulus(1'b0, 4'hF, 32'h304, 32'h0);
    #1;
    checkA("t4_b", 3'd4, 2'd2, 32'h304, 4'hF, 32'h0, 8'd1);
    pushExp(32'hB0B0_B0B0, 1'b0);
    grantAndRelease();
    applyStimulus(1'b0, 4'hF, 32'h308, 32'h0);
    #1;
    checkOutput("t4_full_a_valid", 64'(tl_h_o.a_valid), 64'd0);
    checkOutput("t4_full_gnt",     64'(data_gnt_o),     64'd0);
    @(posedge clk_i);
    #1;
    checkOutput("t4_hold_gnt", 64'(data_gnt_o), 64'd0);
    tl_h_i.d_valid  = 1'b1;
    tl_h_i.d_opcode = AccessAckData;
    tl_h_i.d_data   = 32'hA0A0_A0A0;
    tl_h_i.d_source = 8'd0;
    #1;
    checkOutput("t4_same_cycle_gnt", 64'(data_gnt_o), 64'd0);
    @(posedge clk_i);
    #1;
    tl_h_i.d_valid = 1'b0;
    #1;
    checkA("t4_c", 3'd4, 2'd2, 32'h308, 4'hF, 32'h0, 8'd2);
    pushExp(32'hC0C0_C0C0, 1'b0);
    grantAndRelease();
    respond(AccessAckData, 32'hB0B0_B0B0, 8'd1, 1'b0);
    respond(AccessAckData, 32'hC0C0_C0C0, 8'd2, 1'b0);

    $display("[TB] error reporting");
    applyStimulus(1'b0, 4'hF, 32'h400, 32'h0);
    #1;
    checkA("t5_a", 3'd4, 2'd2, 32'h400, 4'hF, 32'h0, 8'd3);
    pushExp(32'hCAFE_0000, 1'b1);
    grantAndRelease();
    respond(AccessAckData, 32'hCAFE_0000, 8'd3, 1'b1);
    applyStimulus(1'b0, 4'hF, 32'h404, 32'h0);
    #1;
    checkA("t5_b", 3'd4, 2'd2, 32'h404, 4'hF, 32'h0, 8'd0);
    pushExp(32'h0000_1234, 1'b1);
    grantAndRelease();
    respond(AccessAckData, 32'h0000_1234, 8'd3, 1'b0);
    applyStimulus(1'b0, 4'hF, 32'h408, 32'h0);
    #1;
    checkA("t5_c", 3'd4, 2'd2, 32'h408, 4'hF, 32'h0, 8'd1);
    pushExp(32'h0000_5678, 1'b0);
    grantAndRelease();
    respond(AccessAckData, 32'h0000_5678, 8'd1, 1'b0);
    tl_h_i.d_valid  = 1'b1;
    tl_h_i.d_source = 8'd2;
    tl_h_i.d_data   = 32'h9999_9999;
    #1;
    checkOutput("t5_spurious_rvalid", 64'(data_rvalid_o), 64'd0);
    checkOutput("t5_spurious_rdata",  64'(data_rdata_o),  64'd0);
    @(posedge clk_i);
    #1;
    tl_h_i.d_valid = 1'b0;

    $display("[TB] reset with requests in flight");
    applyStimulus(1'b0, 4'hF, 32'h500, 32'h0);
    #1;
    checkOutput("t6_pre_gnt0", 64'(data_gnt_o), 64'd1);
    grantAndRelease();
    applyStimulus(1'b0, 4'hF, 32'h504, 32'h0);
    #1;
    checkOutput("t6_pre_gnt1", 64'(data_gnt_o), 64'd1);
    grantAndRelease();
    resetDut();
    tl_h_i.d_valid  = 1'b1;
    tl_h_i.d_opcode = AccessAckData;
    tl_h_i.d_source = 8'd2;
    tl_h_i.d_data   = 32'h5A5A_5A5A;
    #1;
    checkOutput("t6_stale_rvalid", 64'(data_rvalid_o), 64'd0);
    @(posedge clk_i);
    #1;
    tl_h_i.d_valid = 1'b0;
    applyStimulus(1'b0, 4'hF, 32'h600, 32'h0);
    #1;
    checkA("t6_a", 3'd4, 2'd2, 32'h600, 4'hF, 32'h0, 8'd0);
    pushExp(32'h6000_0000, 1'b0);
    grantAndRelease();
    applyStimulus(1'b0, 4'hF, 32'h604, 32'h0);
    #1;
    checkA("t6_b", 3'd4, 2'd2, 32'h604, 4'hF, 32'h0, 8'd1);
    pushExp(32'h6000_0004, 1'b0);
    grantAndRelease();
    applyStimulus(1'b0, 4'hF, 32'h608, 32'h0);
    #1;
    checkOutput("t6_full_a_valid", 64'(tl_h_o.a_valid), 64'd0);
    data_req_i = 1'b0;
    respond(AccessAckData, 32'h6000_0000, 8'd0, 1'b0);
    respond(AccessAckData, 32'h6000_0004, 8'd1, 1'b0);

    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("pending_rsp", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
